dmem_responder: RTL and testbench

- Data-memory responder for the hart's dmem port; replaces the combinational DFF-style memory model with a realistic multi-cycle memory.
- Accepts word-aligned read/write requests with a byte mask through a ready/valid request handshake.
- Performs masked byte-lane writes and masked reads into internal storage.
- Returns a single response (data plus error flag) after a fixed, parameterised latency.

---
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with fixed response latency, byte-masked access and request checking
// Ports:
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_req_addr/ren/wen/wdata/mask       request, accepted while o_req_ready is high
//   o_req_ready                         high only in IDLE
//   o_rsp_valid                         one-cycle response pulse
//   o_rsp_rdata, o_rsp_err              response payload, held until the next response
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    localparam int          IW       = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_mask;
    logic        lat_wen, lat_err;
    logic [31:0] cur_addr, cur_wdata, rd_word;
    logic [3:0]  cur_mask;
    logic        cur_wen, cur_err, req_err, accept, commit;
    logic [IW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];

    assign accept  = state == IDLE && (i_req_ren || i_req_wen);
    // 33-bit compare so a window ending at 2^32 does not wrap
    assign req_err = i_req_addr[1:0] != 2'b00 || (i_req_ren && i_req_wen) || i_req_mask == 4'h0 ||
                     {1'b0, i_req_addr} < {1'b0, BASE_ADDR} || {1'b0, i_req_addr} >= LIMIT;
    // with LATENCY=1 the commit edge is the accept edge, so the live request is used before it is latched
    assign cur_addr  = state == IDLE ? i_req_addr  : lat_addr;
    assign cur_wdata = state == IDLE ? i_req_wdata : lat_wdata;
    assign cur_mask  = state == IDLE ? i_req_mask  : lat_mask;
    assign cur_wen   = state == IDLE ? i_req_wen   : lat_wen;
    assign cur_err   = state == IDLE ? req_err     : lat_err;
    assign idx       = IW'((cur_addr - BASE_ADDR) >> 2);
    // a reset on the would-be commit edge drops the request entirely
    assign commit    = state_n == RESP && state != RESP && !i_rst;

    assign o_req_ready = state == IDLE;
    assign o_rsp_valid = state == RESP;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (accept) begin
                cnt_n   = CNT_INIT;
                state_n = CNT_INIT == 4'd0 ? RESP : BUSY;
            end
            BUSY: begin
                cnt_n   = cnt - 4'd1;
                state_n = cnt == 4'd1 ? RESP : BUSY;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++)
            rd_word[8*k +: 8] = cur_mask[k] ? mem[idx][8*k +: 8] : 8'h00;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_addr  <= i_req_addr;
                lat_wdata <= i_req_wdata;
                lat_mask  <= i_req_mask;
                lat_wen   <= i_req_wen;
                lat_err   <= req_err;
            end
            if (commit) begin
                o_rsp_err   <= cur_err;
                o_rsp_rdata <= (cur_err || cur_wen) ? 32'h0 : rd_word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (commit && cur_wen && !cur_err)
            for (int k = 0; k < 4; k++)
                if (cur_mask[k]) mem[idx][8*k +: 8] <= cur_wdata[8*k +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors driven in parallel into LATENCY=1,2,5 responders
module tb_dmem_responder;
    localparam int LS [3] = '{1, 2, 5};

    typedef struct {
        logic [31:0] a;
        logic        r;
        logic        w;
        logic [31:0] d;
        logic [3:0]  m;
        logic        junk;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  mask = '0;
    logic        rdy [3];
    logic        vld [3];
    logic        err [3];
    logic [31:0] rdata [3];

    int          total = 0;
    int          bad = 0;
    int          r_lat [3];
    int          r_pulses [3];
    int          r_rdybad [3];
    logic [31:0] r_rdata [3];
    logic        r_err [3];
    vec_t        v [19];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(1024),
            .LATENCY(g == 0 ? 1 : g == 1 ? 2 : 5),
            .BASE_ADDR(32'h0)
        ) dut (
            .i_clk(clk),
            .i_rst(rst),
            .i_req_addr(addr),
            .i_req_ren(ren),
            .i_req_wen(wen),
            .i_req_wdata(wdata),
            .i_req_mask(mask),
            .o_req_ready(rdy[g]),
            .o_rsp_valid(vld[g]),
            .o_rsp_rdata(rdata[g]),
            .o_rsp_err(err[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                          input logic [3:0] m, input logic junk);
        int n;
        n = 0;
        while (!(rdy[0] && rdy[1] && rdy[2]) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        addr = a; ren = r; wen = w; wdata = d; mask = m;
        for (int i = 0; i < 3; i++) begin
            r_lat[i] = 0; r_pulses[i] = 0; r_rdybad[i] = 0; r_rdata[i] = 'x; r_err[i] = 1'bx;
        end
        @(posedge clk); #1;
        if (junk) begin
            addr = 32'h40; ren = 1'b0; wen = 1'b1; wdata = 32'hBAD0_BAD0; mask = 4'hF;
        end else begin
            ren = 1'b0; wen = 1'b0;
        end
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) begin ren = 1'b0; wen = 1'b0; end
            for (int i = 0; i < 3; i++) begin
                if (vld[i]) begin
                    r_pulses[i]++;
                    if (r_lat[i] == 0) begin
                        r_lat[i] = k; r_rdata[i] = rdata[i]; r_err[i] = err[i];
                    end
                end
                if ((r_lat[i] == 0 || r_lat[i] == k) && rdy[i]) r_rdybad[i]++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_rsp(input string tag, input int i, input logic [31:0] er, input logic ee);
        chk($sformatf("%s_L%0d_lat", tag, LS[i]), 32'(r_lat[i]), 32'(LS[i]));
        chk($sformatf("%s_L%0d_pulses", tag, LS[i]), 32'(r_pulses[i]), 32'd1);
        chk($sformatf("%s_L%0d_busy_ready", tag, LS[i]), 32'(r_rdybad[i]), 32'd0);
        chk($sformatf("%s_L%0d_rdata", tag, LS[i]), r_rdata[i], er);
        chk($sformatf("%s_L%0d_err", tag, LS[i]), 32'(r_err[i]), 32'(ee));
    endtask

    initial begin
        int t1 [3];
        int t2 [3];
        int stray;
        v[0]  = '{32'h10,   1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         1'b0};
        v[1]  = '{32'h10,   1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0};
        v[2]  = '{32'h10,   1'b0, 1'b1, 32'h00AA_0000, 4'h4, 1'b0, 32'h0,         1'b0};
        v[3]  = '{32'h10,   1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'hDEAA_BEEF, 1'b0};
        v[4]  = '{32'h10,   1'b1, 1'b0, 32'h0,         4'hC, 1'b0, 32'hDEAA_0000, 1'b0};
        v[5]  = '{32'h12,   1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'h0,         1'b1};
        v[6]  = '{32'h10,   1'b1, 1'b1, 32'h0,         4'hF, 1'b0, 32'h0,         1'b1};
        v[7]  = '{32'h10,   1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'hDEAA_BEEF, 1'b0};
        v[8]  = '{32'h1000, 1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'h0,         1'b1};
        v[9]  = '{32'h1000, 1'b0, 1'b1, 32'h1,         4'hF, 1'b0, 32'h0,         1'b1};
        v[10] = '{32'h10,   1'b1, 1'b0, 32'h0,         4'h0, 1'b0, 32'h0,         1'b1};
        v[11] = '{32'hFFC,  1'b0, 1'b1, 32'h1122_3344, 4'hF, 1'b0, 32'h0,         1'b0};
        v[12] = '{32'hFFC,  1'b1, 1'b0, 32'h0,         4'h1, 1'b0, 32'h0000_0044, 1'b0};
        v[13] = '{32'h10,   1'b1, 1'b0, 32'h0,         4'h3, 1'b0, 32'h0000_BEEF, 1'b0};
        v[14] = '{32'h20,   1'b0, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         1'b0};
        v[15] = '{32'h40,   1'b0, 1'b1, 32'h5566_7788, 4'hF, 1'b0, 32'h0,         1'b0};
        v[16] = '{32'h10,   1'b1, 1'b0, 32'h0,         4'hF, 1'b1, 32'hDEAA_BEEF, 1'b0};
        v[17] = '{32'h40,   1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'h5566_7788, 1'b0};
        v[18] = '{32'h20,   1'b1, 1'b0, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D, 1'b0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_L%0d_ready", LS[i]), 32'(rdy[i]), 32'd1);
            chk($sformatf("reset_L%0d_valid", LS[i]), 32'(vld[i]), 32'd0);
            chk($sformatf("reset_L%0d_rdata", LS[i]), rdata[i], 32'h0);
            chk($sformatf("reset_L%0d_err", LS[i]), 32'(err[i]), 32'd0);
        end
        stray = 0;
        repeat (5) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (vld[i] !== 1'b0) stray++;
        end
        chk("idle_no_pulse", 32'(stray), 32'd0);

        for (int j = 0; j < 19; j++) begin
            do_req(v[j].a, v[j].r, v[j].w, v[j].d, v[j].m, v[j].junk);
            for (int i = 0; i < 3; i++) chk_rsp($sformatf("v%0d", j), i, v[j].er, v[j].ee);
        end

        addr = 32'h20; ren = 1'b0; wen = 1'b1; wdata = 32'h1234_5678; mask = 4'hF;
        @(posedge clk); #1;
        wen = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("midrst_L%0d_ready", LS[i]), 32'(rdy[i]), 32'd1);
        stray = 0;
        repeat (8) begin
            for (int i = 0; i < 3; i++) if (vld[i] !== 1'b0) stray++;
            @(posedge clk); #1;
        end
        chk("midrst_no_pulse", 32'(stray), 32'd0);
        do_req(32'h20, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0);
        chk_rsp("midrst_read", 0, 32'h1234_5678, 1'b0);
        chk_rsp("midrst_read", 1, 32'hCAFE_F00D, 1'b0);
        chk_rsp("midrst_read", 2, 32'hCAFE_F00D, 1'b0);

        for (int i = 0; i < 3; i++) begin t1[i] = 0; t2[i] = 0; end
        addr = 32'h10; ren = 1'b1; wen = 1'b0; mask = 4'hF;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (vld[i]) begin
                    if (t1[i] == 0) t1[i] = k;
                    else if (t2[i] == 0) t2[i] = k;
                end
        end
        ren = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_L%0d_first", LS[i]), 32'(t1[i]), 32'(LS[i]));
            chk($sformatf("b2b_L%0d_period", LS[i]), 32'(t2[i] - t1[i]), 32'(LS[i] + 1));
            chk($sformatf("b2b_L%0d_rdata", LS[i]), rdata[i], 32'hDEAA_BEEF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
